// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin sharing of one SD CMD17 single-block read engine between two requesters.
// Define SD_ARB_BYTE_ADDR_EN to shift the block number into a byte address for standard-capacity cards.
module sd_read_arbiter #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_W   = 16,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic        busy,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic        data_owner,
  output logic [6:0]  sd_cmd,
  output logic [31:0] sd_address,
  output logic        sd_en,
  input  logic        sd_rdy,
  input  logic        sd_valid_status,
  input  logic [6:0]  sd_resp_status,
  input  logic [7:0]  sd_data_in,
  input  logic        sd_data_in_valid
);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, DATA, DONE} state_t;
  state_t state;
  logic owner, last, grant, tmo_full, last_byte, fail;
  logic [BW-1:0] byte_cnt;
  logic [TIMEOUT_W-1:0] tmo;
  logic [RW-1:0] retry;
  logic [31:0] gaddr, addr_x;
  always_comb begin
    grant = &req ? ~last : req[1];
    gaddr = grant ? addr1 : addr0;
    tmo_full = &tmo;
    last_byte = byte_cnt == BW'(BLOCK_BYTES - 1);
    // status beats timeout, and an arriving byte beats timeout
    fail = state == WAIT_RESP ? (sd_valid_status ? |sd_resp_status : tmo_full)
                              : state == DATA && !sd_data_in_valid && tmo_full;
  end
`ifdef SD_ARB_BYTE_ADDR_EN
  assign addr_x = {gaddr[22:0], 9'b0};
`else
  assign addr_x = gaddr;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      byte_cnt <= '0;
      tmo <= '0;
      retry <= '0;
      ack <= '0;
      err <= '0;
      busy <= 1'b0;
      data_out <= '0;
      data_out_valid <= 1'b0;
      data_owner <= 1'b0;
      sd_cmd <= '0;
      sd_address <= '0;
      sd_en <= 1'b0;
    end else begin
      sd_en <= 1'b0;
      ack <= '0;
      err <= '0;
      data_out_valid <= 1'b0;
      if (state == WAIT_RESP || state == DATA) tmo <= tmo_full ? tmo : tmo + 1'b1;
      if (fail) begin
        if (retry < RW'(MAX_RETRY)) begin
          retry <= retry + 1'b1;
          state <= ISSUE;
        end else begin
          state <= DONE;
          ack[owner] <= 1'b1;
          err[owner] <= 1'b1;
          sd_cmd <= '0;
          sd_address <= '0;
        end
      end else begin
        case (state)
          IDLE: if (|req) begin
            owner <= grant;
            sd_address <= addr_x;
            sd_cmd <= 7'd17;
            busy <= 1'b1;
            state <= ISSUE;
          end
          ISSUE: if (sd_rdy) begin
            sd_en <= 1'b1;
            tmo <= '0;
            state <= WAIT_RESP;
          end
          WAIT_RESP: if (sd_valid_status) begin
            byte_cnt <= '0;
            state <= DATA;
          end
          DATA: if (sd_data_in_valid) begin
            data_out <= sd_data_in;
            data_out_valid <= 1'b1;
            data_owner <= owner;
            byte_cnt <= byte_cnt + 1'b1;
            tmo <= '0;
            if (last_byte) begin
              state <= DONE;
              ack[owner] <= 1'b1;
              sd_cmd <= '0;
              sd_address <= '0;
            end
          end
          DONE: begin
            last <= owner;
            busy <= 1'b0;
            retry <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Sequencer/arbiter that shares one SD SPI command engine (single-block read path) between two requesters.
- Per granted request:
  - issues CMD17 (read single block) with the requester's address;
  - waits for the R1 status;
  - streams the data-block bytes back, tagged with the owner;
  - retries on error or timeout.
- Sits between the application masters and the SD controller's cmd/address/en/rdy/status/data interface.

Parameters:
- BLOCK_BYTES, 512: data bytes expected per block read.
- TIMEOUT_W, 16: width of the no-progress timeout counter; timeout fires at 2^TIMEOUT_W-1 idle cycles.
- MAX_RETRY, 3: command re-issues allowed after the first attempt before reporting error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req  in  2  per-requester read request; held high until its ack
- addr0  in  32  requester 0 block address
- addr1  in  32  requester 1 block address
- ack  out  2  one-cycle completion pulse per requester
- err  out  2  one-cycle error flag, coincident with ack
- busy  out  1  transaction in progress
- data_out  out  8  forwarded block byte
- data_out_valid  out  1  data_out qualifier
- data_owner  out  1  index of requester owning data_out
- sd_cmd  out  7  command index to SD engine (17 during a read, else 0)
- sd_address  out  32  argument to SD engine
- sd_en  out  1  one-cycle command start
- sd_rdy  in  1  SD engine idle/ready
- sd_valid_status  in  1  R1 status valid strobe
- sd_resp_status  in  7  R1 status bits
- sd_data_in  in  8  block byte from SD engine
- sd_data_in_valid  in  1  byte strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE;
  - all outputs 0;
  - last-grant pointer = 1, so requester 0 wins first;
  - byte, timeout and retry counters = 0.
  - Reset asserted mid-transaction aborts it immediately: no ack or err is issued.
- FSM states: IDLE, ISSUE, WAIT_RESP, DATA, DONE.
- IDLE:
  - If any req bit is set, grant round-robin: if both are set, grant the index != last grant; else grant the set one.
  - Latch owner and address (addr is sampled only here).
  - Set busy=1, go to ISSUE.
  - Grant latency from req rise to ISSUE: 1 cycle.
- ISSUE:
  - sd_cmd=17 and sd_address=latched address are held stable through WAIT_RESP and DATA.
  - When sd_rdy=1: sd_en=1 for exactly one cycle, clear timeout counter, go to WAIT_RESP.
  - If sd_rdy=0: wait; no timeout in ISSUE.
- WAIT_RESP:
  - On sd_valid_status with sd_resp_status==0: go to DATA with byte count 0.
  - On nonzero status, or timeout: retry.
- DATA:
  - Each sd_data_in_valid forwards the byte to data_out with data_out_valid=1 and data_owner=owner on the next cycle (1-cycle registered latency), increments the byte count and clears the timeout counter.
  - When the count reaches BLOCK_BYTES: go to DONE.
  - Timeout: retry. Bytes already forwarded are not recalled; the requester discards a partial block whenever err or a retry restart occurs.
  - Extra sd_data_in_valid strobes outside DATA are ignored.
- Retry:
  - If retry count < MAX_RETRY: increment it and go to ISSUE with the same address.
  - Otherwise go to DONE with the error flag set.
- DONE (1 cycle):
  - ack[owner]=1; err[owner]=error flag.
  - Update last grant to owner; clear busy, retry count and error flag; go to IDLE.
  - A req still high in the next cycle starts a new transaction; the requester must drop req on ack to avoid a repeat.
- Timeout counter:
  - Increments every cycle in WAIT_RESP/DATA.
  - Saturates and fires at 2^TIMEOUT_W-1.
- Simultaneous events:
  - sd_valid_status and timeout in the same cycle: status wins.
  - Final byte and timeout in the same cycle: the byte wins and the block completes.

Optional Feature:
- Macro SD_ARB_BYTE_ADDR_EN.
- Defined: sd_address = {latched addr[22:0], 9'b0}, i.e. block number converted to byte address for standard-capacity cards.
- Undefined: sd_address = latched addr unchanged (block addressing).

Test Plan:
- req=2'b01, addr0=0x10:
  - expect sd_en pulse with sd_cmd=17, sd_address=0x10 (0x2000 with macro);
  - status 0, then 512 bytes 0x00..0xFF repeating → 512 data_out_valid with owner=0, then ack=2'b01, err=0.
- req=2'b11 held through 3 transactions:
  - grant order 0,1,0;
  - data_owner matches each;
  - ack pulses alternate.
- First status 0x04, second status 0x00:
  - exactly two sd_en pulses;
  - block completes; err=0.
- Status 0x04 on every attempt:
  - 4 sd_en pulses (MAX_RETRY=3);
  - then ack[0]=1 with err[0]=1, no data expected.
- TIMEOUT_W=4, no status after sd_en:
  - re-issue after 15 cycles;
  - after 4 attempts, ack+err.
- Assert rst=0 at byte 100 of DATA:
  - all outputs 0 immediately;
  - no ack;
  - after release, req=2'b10 grants requester 0 first only if req0 is also set (last grant reset to 1).
